// File: rtl/tx_link_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_link_sequencer : picks one symbol per clock for the 8b/10b encoder    |
// |   (training commas, idle, SOF/EOF, framed data, forced commas, CRC-8).   |
// |   Optional CRC-8 state enabled by defining TX_SEQ_CRC_EN.                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tx_link_sequencer #(
   parameter int TRAIN_LEN      = 16,
   parameter int COMMA_INTERVAL = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_valid,
   input  logic [7:0] frame_data,
   input  logic       frame_last,
   output logic       frame_ready,
   output logic [7:0] sym_data,
   output logic       sym_k,
   output logic       link_ready,
   output logic       busy
);

   localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
   localparam int CW = $clog2(COMMA_INTERVAL);

   localparam logic [7:0]    c_K28_5     = 8'hBC;
   localparam logic [7:0]    c_K27_7     = 8'hFB;
   localparam logic [7:0]    c_K29_7     = 8'hFD;
   localparam logic [TW-1:0] c_TRAIN_MAX = TW'(TRAIN_LEN - 1);
   localparam logic [CW-1:0] c_COMMA_MAX = CW'(COMMA_INTERVAL - 1);

   typedef enum logic [2:0] {
      ST_TRAIN = 3'd0,
      ST_IDLE  = 3'd1,
      ST_DATA  = 3'd2,
`ifdef TX_SEQ_CRC_EN
      ST_CRC   = 3'd4,
`endif
      ST_EOF   = 3'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [TW-1:0]   r_train_cnt;
   logic [CW-1:0]   r_comma_cnt;
   logic [7:0]      r_sym_data;
   logic            r_sym_k;
   logic            r_link_ready;
   logic [7:0]      w_sym_data_nxt;
   logic            w_sym_k_nxt;
   logic            w_comma_due;
   logic            w_accept;
   logic            w_sof;
   logic            w_load_comma;

`ifdef TX_SEQ_CRC_EN
   logic [7:0]      r_crc;

   // CRC-8, poly 0x07, MSB first
   function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] d);
      logic [7:0] c;
      c = crc ^ d;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      end
      return c;
   endfunction
`endif

   assign w_comma_due  = (r_comma_cnt == c_COMMA_MAX);
   assign frame_ready  = (r_state == ST_DATA) && !w_comma_due;
   assign busy         = (r_state != ST_TRAIN) && (r_state != ST_IDLE);
   assign sym_data     = r_sym_data;
   assign sym_k        = r_sym_k;
   assign link_ready   = r_link_ready;
   assign w_load_comma = w_sym_k_nxt && (w_sym_data_nxt == c_K28_5);

   always_comb begin
      w_state_nxt    = r_state;
      w_sym_data_nxt = c_K28_5;
      w_sym_k_nxt    = 1'b1;
      w_accept       = 1'b0;
      w_sof          = 1'b0;
      case (r_state)
         ST_TRAIN: begin
            if (r_train_cnt == c_TRAIN_MAX) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (frame_valid) begin
               w_sym_data_nxt = c_K27_7;
               w_sof          = 1'b1;
               w_state_nxt    = ST_DATA;
            end
         end
         ST_DATA: begin
            // An underrun or a due comma both leave the K28.5 default in place
            if (!w_comma_due && frame_valid) begin
               w_accept       = 1'b1;
               w_sym_data_nxt = frame_data;
               w_sym_k_nxt    = 1'b0;
               if (frame_last) begin
`ifdef TX_SEQ_CRC_EN
                  w_state_nxt = ST_CRC;
`else
                  w_state_nxt = ST_EOF;
`endif
               end
            end
         end
`ifdef TX_SEQ_CRC_EN
         ST_CRC: begin
            w_sym_data_nxt = r_crc;
            w_sym_k_nxt    = 1'b0;
            w_state_nxt    = ST_EOF;
         end
`endif
         ST_EOF: begin
            w_sym_data_nxt = c_K29_7;
            w_state_nxt    = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_TRAIN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_TRAIN;
         r_train_cnt  <= '0;
         r_comma_cnt  <= '0;
         r_sym_data   <= c_K28_5;
         r_sym_k      <= 1'b1;
         r_link_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_sym_data <= w_sym_data_nxt;
         r_sym_k    <= w_sym_k_nxt;
         if (r_state == ST_TRAIN) begin
            if (r_train_cnt == c_TRAIN_MAX) begin
               r_link_ready <= 1'b1;
            end else begin
               r_train_cnt <= r_train_cnt + TW'(1);
            end
         end
         if (w_load_comma) begin
            r_comma_cnt <= '0;
         end else if (!w_comma_due) begin
            r_comma_cnt <= r_comma_cnt + CW'(1);
         end
      end
   end

`ifdef TX_SEQ_CRC_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_crc <= 8'h00;
      end else if (w_sof) begin
         r_crc <= 8'h00;
      end else if (w_accept) begin
         r_crc <= crc8_next(r_crc, frame_data);
      end
   end
`endif

endmodule
`default_nettype wire
